// File: rtl/muldiv_pkg.sv
// Shared types for the MULT/MULTU/DIV/DIVU sequencer: op codes, FSM states,
// step modes and the iteration-counter width helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } md_step_e;

  localparam int MD_WIDTH = 32;

  function automatic int md_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int MD_CNT_W = md_cnt_w(MD_WIDTH);

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the CPU control path (master) and muldiv_seq (slave).
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add accumulate for multiply, or
// restoring shift/compare/subtract producing one quotient bit for divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_step_e         mode_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   acc_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] divisor;
  logic [WIDTH:0] addend;

  always_comb begin
    shifted = {acc_i, bit_i};
    divisor = {1'b0, operand_i};
    addend  = bit_i ? divisor : '0;
    acc_o   = {1'b0, acc_i} + addend;
    qbit_o  = 1'b0;
    if (mode_i == STEP_DIV) begin
      // remainder < divisor on entry, so a successful subtract always fits WIDTH bits
      if (shifted >= divisor) begin
        acc_o  = shifted - divisor;
        qbit_o = 1'b1;
      end else begin
        acc_o = shifted;
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Optional multiply early-out
// is enabled by defining MULDIV_EARLY_OUT_EN.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  muldiv_if.slave   md_if
);

  localparam int CNT_W = md_cnt_w(WIDTH);

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_d;
  logic [WIDTH-1:0]   hi_acc_q, hi_acc_d;
  logic [WIDTH-1:0]   lo_acc_q, lo_acc_d;
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;

  logic               is_div;
  logic               signed_op;
  logic               div_zero;
  logic               early_out;
  logic               busy;
  logic               done;
  md_step_e           step_mode;
  logic               step_bit;
  logic [WIDTH:0]     step_acc;
  logic               step_qbit;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_prod;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign is_div    = md_is_div(op_q);
  assign signed_op = md_is_signed(op_q);
  assign div_zero  = is_div && (operand_q == '0);

  assign step_mode = is_div ? STEP_DIV : STEP_MUL;
  assign step_bit  = is_div ? lo_acc_q[WIDTH-1] : lo_acc_q[0];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_i    (step_mode),
    .acc_i     (hi_acc_q),
    .operand_i (operand_q),
    .bit_i     (step_bit),
    .acc_o     (step_acc),
    .qbit_o    (step_qbit)
  );

  assign mul_step = {step_acc, lo_acc_q[WIDTH-1:1]};
  assign mul_prod = {hi_acc_q, lo_acc_q};

`ifdef MULDIV_EARLY_OUT_EN
  // lo_acc_q[cnt_q:1] are the multiplier bits still waiting to be consumed
  logic rest_zero;
  always_comb begin
    rest_zero = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      if ((i <= int'(cnt_q)) && lo_acc_q[i]) rest_zero = 1'b0;
    end
  end
  assign early_out = !is_div && (cnt_q != '0) && rest_zero;
  assign mul_next  = early_out ? (mul_step >> cnt_q) : mul_step;
`else
  assign early_out = 1'b0;
  assign mul_next  = mul_step;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (md_if.start) state_d = PREP;
      PREP: state_d = div_zero ? DONE : ITER;
      ITER: if ((cnt_q == '0) || early_out) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      PREP, ITER, FIX: busy = 1'b1;
      DONE:            done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    hi_acc_d   = hi_acc_q;
    lo_acc_d   = lo_acc_q;
    operand_d  = operand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dbz_d      = dbz_q;
    case (state_q)
      IDLE: begin
        if (md_if.start) begin
          op_d      = md_op_e'(md_if.op);
          lo_acc_d  = md_if.a;
          operand_d = md_if.b;
          dbz_d     = 1'b0;
        end
      end
      PREP: begin
        hi_acc_d = '0;
        cnt_d    = CNT_W'(WIDTH - 1);
        if (div_zero) begin
          hi_d  = lo_acc_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else if (is_div) begin
          lo_acc_d   = mag(lo_acc_q, signed_op);
          operand_d  = mag(operand_q, signed_op);
          neg_quot_d = signed_op && (lo_acc_q[WIDTH-1] ^ operand_q[WIDTH-1]);
          neg_rem_d  = signed_op && lo_acc_q[WIDTH-1];
        end else begin
          // multiplier (b) goes into the low half so it shifts out bit by bit
          lo_acc_d   = mag(operand_q, signed_op);
          operand_d  = mag(lo_acc_q, signed_op);
          neg_quot_d = signed_op && (lo_acc_q[WIDTH-1] ^ operand_q[WIDTH-1]);
          neg_rem_d  = 1'b0;
        end
      end
      ITER: begin
        cnt_d = cnt_q - 1'b1;
        if (is_div) begin
          hi_acc_d = step_acc[WIDTH-1:0];
          lo_acc_d = {lo_acc_q[WIDTH-2:0], step_qbit};
        end else begin
          {hi_acc_d, lo_acc_d} = mul_next;
        end
      end
      FIX: begin
        if (is_div) begin
          lo_d = neg_quot_q ? -lo_acc_q : lo_acc_q;
          hi_d = neg_rem_q ? -hi_acc_q : hi_acc_q;
        end else begin
          {hi_d, lo_d} = neg_quot_q ? -mul_prod : mul_prod;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= MD_MULT;
      hi_acc_q   <= '0;
      lo_acc_q   <= '0;
      operand_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      op_q       <= op_d;
      hi_acc_q   <= hi_acc_d;
      lo_acc_q   <= lo_acc_d;
      operand_q  <= operand_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dbz_q      <= dbz_d;
    end
  end

  assign md_if.busy        = busy;
  assign md_if.done        = done;
  assign md_if.div_by_zero = dbz_q;
  assign md_if.hi          = hi_q;
  assign md_if.lo          = lo_q;

endmodule
